// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and serialises each byte as a UART frame
// (start bit, data LSB-first, optional parity bit, stop bit).
// All outputs are registered. Each register loads a next-state value that the
// combinational block computes, so no input reaches an output combinationally.
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [15:0]       frame_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam bit HAS_PARITY = (PARITY_EN != 0);
    localparam bit ODD_PARITY = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Parity bit for a data word: even parity makes the total count of ones even.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [BAUD_W-1:0]   baud_r, baud_nxt_s;
    logic [BIT_W-1:0]    bit_r, bit_nxt_s;
    logic [DATA_W-1:0]   shift_r, shift_nxt_s;
    logic                par_r, par_nxt_s;
    logic                tx_r, tx_nxt_s;
    logic                rd_en_r, rd_en_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic [15:0]         count_r, count_nxt_s;
    logic                baud_end_s;

    assign baud_end_s  = (baud_r == BAUD_LAST);
    assign rd_en       = rd_en_r;
    assign tx          = tx_r;
    assign tx_busy     = busy_r;
    assign tx_done     = done_r;
    assign frame_count = count_r;

    // Next-state, next-output and datapath computation for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = {BAUD_W{1'b0}};
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        tx_nxt_s    = 1'b1;
        done_nxt_s  = 1'b0;
        count_nxt_s = count_r;
        case (state_r)
            ST_IDLE: begin
                bit_nxt_s = {BIT_W{1'b0}};
                if (tx_en && !buf_empty) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_LOAD;
            end
            ST_LOAD: begin
                // FIFO read data is valid now, one cycle after the pop strobe.
                shift_nxt_s = buf_out;
                par_nxt_s   = parity_bit(buf_out, ODD_PARITY);
                tx_nxt_s    = 1'b0;
                state_nxt_s = ST_START;
            end
            ST_START: begin
                tx_nxt_s = 1'b0;
                if (baud_end_s) begin
                    state_nxt_s = ST_DATA;
                    tx_nxt_s    = shift_r[0];
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                tx_nxt_s = shift_r[0];
                if (baud_end_s) begin
                    if (bit_r == BIT_LAST) begin
                        bit_nxt_s = {BIT_W{1'b0}};
                        if (HAS_PARITY) begin
                            state_nxt_s = ST_PARITY;
                            tx_nxt_s    = par_r;
                        end else begin
                            state_nxt_s = ST_STOP;
                            tx_nxt_s    = 1'b1;
                        end
                    end else begin
                        bit_nxt_s   = bit_r + BIT_ONE;
                        shift_nxt_s = shift_r >> 1;
                        tx_nxt_s    = shift_nxt_s[0];
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_PARITY: begin
                tx_nxt_s = par_r;
                if (baud_end_s) begin
                    state_nxt_s = ST_STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                tx_nxt_s = 1'b1;
                if (baud_end_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                    count_nxt_s = count_r + 16'd1;
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        rd_en_nxt_s = (state_nxt_s == ST_FETCH);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and registered outputs; async reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            par_r   <= par_nxt_s;
            tx_r    <= tx_nxt_s;
            rd_en_r <= rd_en_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three DUTs (default, even parity, odd parity) each fed by a
// behavioural FIFO. Frames are decoded from the tx line by mid-bit sampling and
// compared with the bytes pushed into the FIFO.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst;
    logic tx_en;
    int   sel;

    // Clock generation.
    always #5 clk = ~clk;

    logic [7:0]  bo [3];
    logic [7:0]  mem [3][64];
    int          wp [3];
    int          rp [3];
    int          rdc [3];
    int          dbl [3];
    int          bad [3];
    int          dnc [3];
    int          nfr [3];
    logic [15:0] fc_model [3];
    logic [2:0]  rd_prev;

    logic rd0, rd1, rd2, tx0, tx1, tx2, bz0, bz1, bz2, dn0, dn1, dn2;
    logic be0, be1, be2;
    logic [15:0] fc0, fc1, fc2;
    logic [2:0] rdv, txv, bzv, dnv;
    logic tx_m, done_m, busy_m;
    logic [15:0] fc_m;

    int n_tests = 0;
    int n_fail  = 0;

    assign be0 = (wp[0] == rp[0]);
    assign be1 = (wp[1] == rp[1]);
    assign be2 = (wp[2] == rp[2]);
    assign rdv = {rd2, rd1, rd0};
    assign txv = {tx2, tx1, tx0};
    assign bzv = {bz2, bz1, bz0};
    assign dnv = {dn2, dn1, dn0};

    fifo_uart_tx u_def (
        .clk(clk), .rst(rst), .tx_en(tx_en), .buf_empty(be0), .buf_out(bo[0]),
        .rd_en(rd0), .tx(tx0), .tx_busy(bz0), .tx_done(dn0), .frame_count(fc0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_en(tx_en), .buf_empty(be1), .buf_out(bo[1]),
        .rd_en(rd1), .tx(tx1), .tx_busy(bz1), .tx_done(dn1), .frame_count(fc1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_en(tx_en), .buf_empty(be2), .buf_out(bo[2]),
        .rd_en(rd2), .tx(tx2), .tx_busy(bz2), .tx_done(dn2), .frame_count(fc2)
    );

    // Select which DUT the frame decoder watches.
    always_comb begin
        tx_m   = txv[sel];
        done_m = dnv[sel];
        busy_m = bzv[sel];
        case (sel)
            1:       fc_m = fc1;
            2:       fc_m = fc2;
            default: fc_m = fc0;
        endcase
    end

    // Behavioural FIFOs: read data appears one clock after rd_en is sampled; pulse bookkeeping.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdv[k] && (rp[k] != wp[k])) begin
                bo[k] <= mem[k][rp[k] % 64];
                rp[k] <= rp[k] + 1;
            end
            if (rdv[k]) rdc[k] <= rdc[k] + 1;
            if (rdv[k] && (rp[k] == wp[k])) bad[k] <= bad[k] + 1;
            if (rdv[k] && rd_prev[k]) dbl[k] <= dbl[k] + 1;
            if (dnv[k]) dnc[k] <= dnc[k] + 1;
        end
        rd_prev <= rdv;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wp[k] % 64] = d;
        wp[k] = wp[k] + 1;
    endtask

    // Count falling clock edges until the watched line is seen low.
    task automatic wait_low(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 4000 && !ok) begin
            @(negedge clk);
            n++;
            if (tx_m === 1'b0) ok = 1'b1;
        end
        if (!ok) check("start_timeout", 32'd0, 32'd1);
    endtask

    // Receive one frame from the watched DUT and compare it with the expected byte.
    task automatic rx_frame(input string tag, input int cpb, input int par_en, input int odd,
                            input logic [7:0] exp, output int gap);
        int nb, flen, i;
        bit ok, seen;
        logic [11:0] bits;
        logic [7:0]  got;
        nb   = 10 + par_en;
        flen = nb * cpb;
        bits = 12'h000;
        wait_low(gap, ok);
        if (!ok) return;
        i    = 0;
        seen = 1'b0;
        while (i < flen + 2 * cpb && !seen) begin
            @(negedge clk);
            i++;
            if ((i % cpb) == (cpb / 2) && (i / cpb) < nb) bits[i / cpb] = tx_m;
            if (done_m === 1'b1) seen = 1'b1;
        end
        for (int j = 0; j < 8; j++) got[j] = bits[j + 1];
        check({tag, "_len"},   i, flen);
        check({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
        check({tag, "_data"},  {24'd0, got}, {24'd0, exp});
        if (par_en != 0) begin
            check({tag, "_par"}, {31'd0, bits[9]}, {31'd0, (^exp) ^ (odd != 0)});
        end
        check({tag, "_stop"}, {31'd0, bits[nb - 1]}, 32'd1);
        fc_model[sel] = fc_model[sel] + 16'd1;
        nfr[sel]++;
        check({tag, "_fcount"}, {16'd0, fc_m}, {16'd0, fc_model[sel]});
    endtask

    initial begin
        int g;
        bit ok;
        int exp_rd;
        logic [7:0] b [4];
        for (int k = 0; k < 3; k++) begin
            wp[k] = 0; rp[k] = 0; rdc[k] = 0; dbl[k] = 0; bad[k] = 0; dnc[k] = 0;
            nfr[k] = 0; fc_model[k] = 16'd0; bo[k] = 8'h00;
        end
        rd_prev = 3'b000;
        sel    = 0;
        exp_rd = 0;
        rst    = 1'b0;
        tx_en  = 1'b1;
        push(0, 8'h64);

        // Reset held with a non-empty FIFO: nothing may be popped or sent.
        repeat (20) @(negedge clk);
        check("rst_tx",    {31'd0, tx0}, 32'd1);
        check("rst_rd",    rdc[0], 0);
        check("rst_busy",  {31'd0, bz0}, 32'd0);
        check("rst_done",  {31'd0, dn0}, 32'd0);
        check("rst_fcount", {16'd0, fc0}, 32'd0);
        rst = 1'b1;

        // Single byte 0x64, including start latency.
        rx_frame("single", 16, 0, 0, 8'h64, g);
        exp_rd += 1;
        check("single_lat", g, 3);
        check("single_rd", rdc[0], exp_rd);

        // Back-to-back random bytes: three-cycle idle gap between frames.
        for (int j = 0; j < 3; j++) begin
            b[j] = 8'($urandom_range(0, 255));
            push(0, b[j]);
        end
        for (int j = 0; j < 3; j++) begin
            rx_frame("b2b", 16, 0, 0, b[j], g);
            check("b2b_gap", g, 3);
        end
        exp_rd += 3;
        @(negedge clk);
        check("b2b_rd", rdc[0], exp_rd);
        check("b2b_empty", {31'd0, be0}, 32'd1);

        // tx_en dropped after the first pop: frame completes, then the line waits.
        b[0] = 8'($urandom_range(0, 255));
        b[1] = 8'($urandom_range(0, 255));
        push(0, b[0]);
        push(0, b[1]);
        @(negedge clk);
        tx_en = 1'b0;
        rx_frame("hold1", 16, 0, 0, b[0], g);
        exp_rd += 1;
        repeat (40) @(negedge clk);
        check("hold_rd", rdc[0], exp_rd);
        check("hold_busy", {31'd0, bz0}, 32'd0);
        check("hold_tx", {31'd0, tx0}, 32'd1);
        tx_en = 1'b1;
        rx_frame("hold2", 16, 0, 0, b[1], g);
        exp_rd += 1;
        check("hold2_lat", g, 3);

        // Reset mid-frame during data bits: line snaps high, popped byte lost.
        b[0] = 8'($urandom_range(0, 255));
        b[1] = 8'($urandom_range(0, 255));
        push(0, b[0]);
        push(0, b[1]);
        wait_low(g, ok);
        repeat (3 * 16) @(negedge clk);
        check("mid_pre_tx_busy", {31'd0, bz0}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx0}, 32'd1);
        check("mid_rst_busy", {31'd0, bz0}, 32'd0);
        check("mid_rst_fcount", {16'd0, fc0}, 32'd0);
        for (int k = 0; k < 3; k++) fc_model[k] = 16'd0;
        exp_rd += 1;
        @(negedge clk);
        rst = 1'b1;
        rx_frame("after_rst", 16, 0, 0, b[1], g);
        check("after_rst_lat", g, 3);
        exp_rd += 1;

        // Random bytes with random idle time between them.
        for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            b[0] = 8'($urandom_range(0, 255));
            push(0, b[0]);
            rx_frame("rand", 16, 0, 0, b[0], g);
            check("rand_lat", g, 3);
            exp_rd += 1;
        end
        @(negedge clk);
        check("def_rd_total", rdc[0], exp_rd);

        // Even parity: 0x07 carries parity bit 1, frame 176 cycles.
        sel = 1;
        push(1, 8'h07);
        rx_frame("even07", 16, 1, 0, 8'h07, g);
        b[0] = 8'($urandom_range(0, 255));
        push(1, b[0]);
        rx_frame("even_rand", 16, 1, 0, b[0], g);

        // Odd parity at a short bit period: 0x07 carries parity bit 0.
        sel = 2;
        push(2, 8'h07);
        rx_frame("odd07", 5, 1, 1, 8'h07, g);
        b[0] = 8'($urandom_range(0, 255));
        push(2, b[0]);
        rx_frame("odd_rand", 5, 1, 1, b[0], g);
        check("odd_lat", g, 3);

        // Pulse-shape bookkeeping over the whole run.
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rd_pulse_width", dbl[k], 0);
            check("rd_when_empty", bad[k], 0);
            check("done_pulses", dnc[k], nfr[k]);
        end
        check("even_rd_total", rdc[1], 2);
        check("odd_rd_total", rdc[2], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
